// File: rtl/mc_pkg.sv
// mc_pkg: shared types and encodings for the multicycle MIPS control FSM.
//   state_t     - controller states (ADDI states exist only with MC_ADDI_EN)
//   OP_*        - primary opcodes recognised in DECODE
//   ALUOP_*, SRCB_*, PCSRC_* - datapath select encodings
//   ctrl_word_t - per-state control bundle produced by mc_output_decode
// Optional feature macro: MC_ADDI_EN (adds the addi instruction path).
package mc_pkg;

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_EXECUTE = 4'd6,
    S_ALUWB   = 4'd7,
    S_BRANCH  = 4'd8,
    S_JUMP    = 4'd9
`ifdef MC_ADDI_EN
    ,
    S_ADDIEX  = 4'd10,
    S_ADDIWB  = 4'd11
`endif
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] SRCB_B       = 2'b00;
  localparam logic [1:0] SRCB_FOUR    = 2'b01;
  localparam logic [1:0] SRCB_IMM     = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

  localparam logic [1:0] PCSRC_ALU     = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT  = 2'b01;
  localparam logic [1:0] PCSRC_JUMP    = 2'b10;

  typedef struct packed {
    logic       iord;
    logic       memwrite;
    logic       irwrite;
    logic       regdst;
    logic       memtoreg;
    logic       regwrite;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic [1:0] aluop;
    logic [1:0] pcsrc;
    logic       pcwrite;
    logic       branch;
  } ctrl_word_t;

endpackage

// File: rtl/mc_output_decode.sv
// mc_output_decode: combinational state -> control word for the multicycle FSM.
//   state     in  current controller state
//   mem_ready in  memory handshake (FETCH loads IR/PC only when memory answers)
//   ctrl      out control bundle; any field not set for a state is 0
// Optional feature macro: MC_ADDI_EN (decodes ADDIEX/ADDIWB).
module mc_output_decode
  import mc_pkg::*;
(
  input  state_t     state,
  input  logic       mem_ready,
  output ctrl_word_t ctrl
);

  always_comb begin
    ctrl = '0;
    case (state)
      S_FETCH: begin
        ctrl.alusrcb = SRCB_FOUR;
        ctrl.irwrite = mem_ready;
        ctrl.pcwrite = mem_ready;
      end
      S_DECODE: begin
        ctrl.alusrcb = SRCB_IMM_SH2;
      end
      S_MEMADR: begin
        ctrl.alusrca = 1'b1;
        ctrl.alusrcb = SRCB_IMM;
      end
      S_MEMRD: begin
        ctrl.iord = 1'b1;
      end
      S_MEMWB: begin
        ctrl.memtoreg = 1'b1;
        ctrl.regwrite = 1'b1;
      end
      S_MEMWR: begin
        ctrl.iord     = 1'b1;
        ctrl.memwrite = 1'b1;
      end
      S_EXECUTE: begin
        ctrl.alusrca = 1'b1;
        ctrl.aluop   = ALUOP_FUNCT;
      end
      S_ALUWB: begin
        ctrl.regdst   = 1'b1;
        ctrl.regwrite = 1'b1;
      end
      S_BRANCH: begin
        ctrl.alusrca = 1'b1;
        ctrl.aluop   = ALUOP_SUB;
        ctrl.pcsrc   = PCSRC_ALUOUT;
        ctrl.branch  = 1'b1;
      end
      S_JUMP: begin
        ctrl.pcsrc   = PCSRC_JUMP;
        ctrl.pcwrite = 1'b1;
      end
`ifdef MC_ADDI_EN
      S_ADDIEX: begin
        ctrl.alusrca = 1'b1;
        ctrl.alusrcb = SRCB_IMM;
      end
      S_ADDIWB: begin
        ctrl.regwrite = 1'b1;
      end
`endif
      default: ctrl = '0;
    endcase
  end

endmodule

// File: rtl/multicycle_controller.sv
// multicycle_controller: main control FSM of the multicycle MIPS datapath.
// Holds the state register, next-state logic, memory-wait counter and the
// PCEn / IllegalOp / MemTimeout logic; per-state controls come from mc_output_decode.
// Ports:
//   Clk, Reset_n (async, active-low)     - clock / reset
//   Op, Zero, MemReady                   - opcode, ALU zero flag, memory handshake
//   IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite, ALUSrcA,
//   ALUSrcB, ALUOp, PCSrc, PCEn          - datapath controls
//   IllegalOp, MemTimeout                - one-cycle event pulses
//   State                                - current state (debug)
// Parameters: OP_W, STATE_W, WAIT_MAX (0 = never time out).
// Optional feature macro: MC_ADDI_EN (addi via ADDIEX/ADDIWB; otherwise 001000 is illegal).
module multicycle_controller
  import mc_pkg::*;
#(
  parameter int OP_W     = 6,
  parameter int STATE_W  = 4,
  parameter int WAIT_MAX = 16
) (
  input  logic               Clk,
  input  logic               Reset_n,
  input  logic [OP_W-1:0]    Op,
  input  logic               Zero,
  input  logic               MemReady,
  output logic               IorD,
  output logic               MemWrite,
  output logic               IRWrite,
  output logic               RegDst,
  output logic               MemtoReg,
  output logic               RegWrite,
  output logic               ALUSrcA,
  output logic [1:0]         ALUSrcB,
  output logic [1:0]         ALUOp,
  output logic [1:0]         PCSrc,
  output logic               PCEn,
  output logic               IllegalOp,
  output logic               MemTimeout,
  output logic [STATE_W-1:0] State
);

  localparam int CNT_W = (WAIT_MAX > 1) ? $clog2(WAIT_MAX) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WAIT_MAX - 1);

  state_t           state_reg, state_next;
  logic [CNT_W-1:0] wait_cnt_reg, wait_cnt_next;
  logic             waiting, timeout, illegal;
  logic [5:0]       op;
  ctrl_word_t       ctrl;

  assign op = 6'(Op);

  always_comb begin
    waiting    = (state_reg == S_FETCH) || (state_reg == S_MEMRD) || (state_reg == S_MEMWR);
    // A ready memory always wins over an expiring wait.
    timeout    = (WAIT_MAX != 0) && waiting && !MemReady && (wait_cnt_reg == CNT_LAST);
    illegal    = 1'b0;
    state_next = state_reg;
    case (state_reg)
      S_FETCH:   if (MemReady) state_next = S_DECODE;
      S_DECODE: begin
        case (op)
          OP_LW, OP_SW: state_next = S_MEMADR;
          OP_RTYPE:     state_next = S_EXECUTE;
          OP_BEQ:       state_next = S_BRANCH;
          OP_J:         state_next = S_JUMP;
`ifdef MC_ADDI_EN
          OP_ADDI:      state_next = S_ADDIEX;
`endif
          default: begin
            illegal    = 1'b1;
            state_next = S_FETCH;
          end
        endcase
      end
      S_MEMADR:  state_next = (op == OP_SW) ? S_MEMWR : S_MEMRD;
      S_MEMRD:   if (MemReady) state_next = S_MEMWB;
      S_MEMWB:   state_next = S_FETCH;
      S_MEMWR:   if (MemReady) state_next = S_FETCH;
      S_EXECUTE: state_next = S_ALUWB;
      S_ALUWB:   state_next = S_FETCH;
      S_BRANCH:  state_next = S_FETCH;
      S_JUMP:    state_next = S_FETCH;
`ifdef MC_ADDI_EN
      S_ADDIEX:  state_next = S_ADDIWB;
      S_ADDIWB:  state_next = S_FETCH;
`endif
      default:   state_next = S_FETCH;
    endcase
    if (timeout) state_next = S_FETCH;

    // Counts only while stalled in a wait state; any exit or timeout restarts it.
    if ((WAIT_MAX != 0) && waiting && !MemReady && !timeout)
      wait_cnt_next = wait_cnt_reg + CNT_W'(1);
    else
      wait_cnt_next = '0;
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_reg    <= S_FETCH;
      wait_cnt_reg <= '0;
    end else begin
      state_reg    <= state_next;
      wait_cnt_reg <= wait_cnt_next;
    end
  end

  mc_output_decode u_decode (
    .state     (state_reg),
    .mem_ready (MemReady),
    .ctrl      (ctrl)
  );

  // Reset forces FETCH asynchronously, which already gives the reset mux
  // selects; enables and pulses are additionally gated so nothing fires
  // while Reset_n is low.
  assign IorD       = ctrl.iord;
  assign RegDst     = ctrl.regdst;
  assign MemtoReg   = ctrl.memtoreg;
  assign ALUSrcA    = ctrl.alusrca;
  assign ALUSrcB    = ctrl.alusrcb;
  assign ALUOp      = ctrl.aluop;
  assign PCSrc      = ctrl.pcsrc;
  assign MemWrite   = ctrl.memwrite & Reset_n;
  assign IRWrite    = ctrl.irwrite & Reset_n;
  assign RegWrite   = ctrl.regwrite & Reset_n;
  assign PCEn       = (ctrl.pcwrite | (ctrl.branch & Zero)) & Reset_n;
  assign IllegalOp  = illegal & Reset_n;
  assign MemTimeout = timeout & Reset_n;
  assign State      = STATE_W'(state_reg);

endmodule
